// File: rtl/traffic_pkg.sv
// Shared encodings for the vehicle light sequencer and the pedestrian controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10
    } veh_light_t;

    typedef enum logic [1:0] {
        PED_DONT_WALK = 2'b00,
        PED_WALK      = 2'b01,
        PED_FLASH     = 2'b10
    } ped_state_t;

    // Exactly one lamp lit: odd parity rules out 0 and 2, the AND term rules out 3.
    function automatic logic light_legal(input logic r, input logic g, input logic y);
        return (r ^ g ^ y) & ~(r & g & y);
    endfunction

endpackage

// File: rtl/ped_signal_ctrl_if.sv
// Bundle of vehicle-light inputs, button request and pedestrian lamp outputs.
interface ped_signal_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             ped_btn;
    logic             rlight;
    logic             glight;
    logic             ylight;
    logic             walk;
    logic             dont_walk;
    logic             req_pending;
    logic [CNT_W-1:0] remain;
    logic             fault;

    modport master (
        output ped_btn, rlight, glight, ylight,
        input  walk, dont_walk, req_pending, remain, fault
    );

    modport slave (
        input  ped_btn, rlight, glight, ylight,
        output walk, dont_walk, req_pending, remain, fault
    );
endinterface

// File: rtl/ped_blink_gen.sv
// Flash divider: output restarts high on clear and toggles every BLINK_DIV enabled cycles.
module ped_blink_gen #(
    parameter int BLINK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic blink_o
);
    localparam int DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(BLINK_DIV - 1);

    logic [DIV_W-1:0] cnt_q;
    logic             blink_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            blink_q <= 1'b1;
        end else if (clr_i) begin
            cnt_q   <= '0;
            blink_q <= 1'b1;
        end else if (en_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                blink_q <= ~blink_q;
            end else begin
                cnt_q <= cnt_q + DIV_W'(1);
            end
        end
    end

    assign blink_o = blink_q;
endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing controller: grants WALK on a fresh vehicle red when a request is
// latched, then a flashing DONT_WALK clearance; illegal light encodings raise a sticky fault.
module ped_signal_ctrl
    import traffic_pkg::*;
#(
    parameter int WALK_CYCLES  = 8,
    parameter int FLASH_CYCLES = 6,
    parameter int BLINK_DIV    = 2,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    ped_signal_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] WALK_INIT  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_INIT = CNT_W'(FLASH_CYCLES - 1);

    ped_state_t       state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic             rlight_q;
    logic             req_q, req_d;
    logic             fault_q, fault_d;
    logic             legal;
    logic             red_rise;
    logic             flash_clr;
    logic             enter_walk;
    logic             blink;

    assign legal    = light_legal(bus.rlight, bus.glight, bus.ylight);
    assign red_rise = bus.rlight & ~rlight_q;

    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        flash_clr = 1'b0;
        case (state_q)
            PED_DONT_WALK: begin
                if (req_q && red_rise && legal && !fault_q) begin
                    state_d  = PED_WALK;
                    remain_d = WALK_INIT;
                end
            end
            PED_WALK: begin
                // Vehicles leaving red or a corrupt encoding ends the crossing at once.
                if (!bus.rlight || !legal) begin
                    state_d  = PED_DONT_WALK;
                    remain_d = '0;
                end else if (remain_q == '0) begin
                    state_d   = PED_FLASH;
                    remain_d  = FLASH_INIT;
                    flash_clr = 1'b1;
                end else begin
                    remain_d = remain_q - 1'b1;
                end
            end
            PED_FLASH: begin
                if (!bus.rlight || !legal || remain_q == '0) begin
                    state_d  = PED_DONT_WALK;
                    remain_d = '0;
                end else begin
                    remain_d = remain_q - 1'b1;
                end
            end
            default: begin
                state_d  = PED_DONT_WALK;
                remain_d = '0;
            end
        endcase
    end

    assign enter_walk = (state_d == PED_WALK) && (state_q != PED_WALK);

    always_comb begin
        req_d = req_q;
        if (enter_walk) begin
            req_d = 1'b0;
        end else if (bus.ped_btn && state_q != PED_WALK) begin
            req_d = 1'b1;
        end
    end

    assign fault_d = fault_q | ~legal;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= PED_DONT_WALK;
            remain_q <= '0;
            rlight_q <= 1'b0;
            req_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            rlight_q <= bus.rlight;
            req_q    <= req_d;
            fault_q  <= fault_d;
        end
    end

    ped_blink_gen #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (flash_clr),
        .en_i    (state_q == PED_FLASH),
        .blink_o (blink)
    );

    assign bus.walk        = (state_q == PED_WALK);
    assign bus.dont_walk   = (state_q == PED_FLASH) ? blink : (state_q != PED_WALK);
    assign bus.req_pending = req_q;
    assign bus.remain      = remain_q;
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Scoreboard bench for ped_signal_ctrl: each driven cycle queues the lamp state expected
// after the next clock edge, which is popped and compared just after that edge.
module tb_ped_signal_ctrl;
    import traffic_pkg::*;

    localparam logic [2:0] L_BAD = 3'b110;

    typedef struct {
        logic w;
        logic dw;
        logic rq;
        logic f;
        int   rem;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    ped_signal_ctrl_if #(.CNT_W(8)) bus ();

    ped_signal_ctrl #(
        .WALK_CYCLES  (8),
        .FLASH_CYCLES (6),
        .BLINK_DIV    (2),
        .CNT_W        (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] lamp(input veh_light_t v);
        case (v)
            RED:     return 3'b100;
            GREEN:   return 3'b010;
            YELLOW:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic btn, input logic [2:0] rgy,
                        input logic rst_n, input logic ew, input logic edw,
                        input logic erq, input int erem, input logic ef);
        exp_t e;
        reset = rst_n;
        bus.ped_btn = btn;
        {bus.rlight, bus.glight, bus.ylight} = rgy;
        e = '{ew, edw, erq, ef, erem};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".walk"},      int'(bus.walk),        int'(e.w));
        check({tag, ".dont_walk"}, int'(bus.dont_walk),   int'(e.dw));
        check({tag, ".req"},       int'(bus.req_pending), int'(e.rq));
        check({tag, ".remain"},    int'(bus.remain),      e.rem);
        check({tag, ".fault"},     int'(bus.fault),       int'(e.f));
    endtask

    // Cycle expected to leave the controller resting in DONT_WALK.
    task automatic idle(input string tag, input logic btn, input logic [2:0] rgy,
                        input logic erq, input logic ef);
        step(tag, btn, rgy, 1'b1, 1'b0, 1'b1, erq, 0, ef);
    endtask

    initial begin
        veh_light_t seq [3];
        seq[0] = RED;
        seq[1] = GREEN;
        seq[2] = YELLOW;
        reset = 1'b0;
        bus.ped_btn = 1'b0;
        {bus.rlight, bus.glight, bus.ylight} = lamp(GREEN);

        for (int i = 0; i < 3; i++) step("reset", 1'b0, lamp(GREEN), 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 30; i++) idle("cycle_nobtn", 1'b0, lamp(seq[i % 3]), 1'b0, 1'b0);

        // Request on green, then a held red: full WALK and FLASH sequence.
        idle("btn_green", 1'b1, lamp(GREEN), 1'b1, 1'b0);
        idle("pending", 1'b0, lamp(GREEN), 1'b1, 1'b0);
        step("walk_entry", 1'b0, lamp(RED), 1'b1, 1'b1, 1'b0, 1'b0, 7, 1'b0);
        for (int k = 2; k <= 8; k++)
            step("walk_btn_ignored", 1'b1, lamp(RED), 1'b1, 1'b1, 1'b0, 1'b0, 8 - k, 1'b0);
        step("flash_entry", 1'b1, lamp(RED), 1'b1, 1'b0, 1'b1, 1'b0, 5, 1'b0);
        for (int j = 1; j <= 5; j++)
            step("flash", (j == 2), lamp(RED), 1'b1, 1'b0, ((j / 2) % 2 == 0), (j >= 2), 5 - j, 1'b0);
        idle("flash_done", 1'b0, lamp(RED), 1'b1, 1'b0);

        // Request latched during FLASH served on the next red; one-cycle red aborts.
        idle("pre_red", 1'b0, lamp(GREEN), 1'b1, 1'b0);
        step("regrant", 1'b0, lamp(RED), 1'b1, 1'b1, 1'b0, 1'b0, 7, 1'b0);
        idle("abort_green", 1'b0, lamp(GREEN), 1'b0, 1'b0);

        // Button on the red_rise cycle itself only latches.
        idle("btn_on_rise", 1'b1, lamp(RED), 1'b1, 1'b0);
        idle("pre_red2", 1'b0, lamp(GREEN), 1'b1, 1'b0);
        step("grant2", 1'b0, lamp(RED), 1'b1, 1'b1, 1'b0, 1'b0, 7, 1'b0);
        idle("abort_yellow", 1'b0, lamp(YELLOW), 1'b0, 1'b0);

        // Illegal encoding: sticky fault, WALK inhibited, latch still works.
        idle("illegal", 1'b0, L_BAD, 1'b0, 1'b1);
        idle("fault_hold", 1'b0, lamp(GREEN), 1'b0, 1'b1);
        idle("fault_btn", 1'b1, lamp(GREEN), 1'b1, 1'b1);
        idle("fault_red", 1'b0, lamp(RED), 1'b1, 1'b1);
        idle("fault_green", 1'b0, lamp(GREEN), 1'b1, 1'b1);
        idle("fault_red2", 1'b0, lamp(RED), 1'b1, 1'b1);

        // Reset clears fault; then reset mid-FLASH with remain=3.
        step("reset2", 1'b0, lamp(GREEN), 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle("btn2", 1'b1, lamp(GREEN), 1'b1, 1'b0);
        step("walk3_entry", 1'b0, lamp(RED), 1'b1, 1'b1, 1'b0, 1'b0, 7, 1'b0);
        for (int k = 2; k <= 8; k++)
            step("walk3", 1'b0, lamp(RED), 1'b1, 1'b1, 1'b0, 1'b0, 8 - k, 1'b0);
        step("flash3_entry", 1'b0, lamp(RED), 1'b1, 1'b0, 1'b1, 1'b0, 5, 1'b0);
        step("flash3_btn", 1'b1, lamp(RED), 1'b1, 1'b0, 1'b1, 1'b1, 4, 1'b0);
        step("flash3_rem3", 1'b0, lamp(RED), 1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b0);
        step("reset_mid_flash", 1'b0, lamp(RED), 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle("post_reset_red", 1'b0, lamp(RED), 1'b0, 1'b0);
        idle("post_reset_green", 1'b0, lamp(GREEN), 1'b0, 1'b0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
